rr_burst_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream beat-level valid/ready port among `N_REQ` requesters. Once granted, a requester holds the port for a whole burst whose length is latched at grant time. An internal beat counter tracks accepted beats and ends the burst. It sits in front of shared memory/bus ports in the machine, for example between fetch, load/store and DMA-style masters and a single memory interface.

---
 rtl/rr_burst_arbiter_pkg.sv | 32 +++
 rtl/rr_burst_arbiter_if.sv | 30 +++
 rtl/rr_burst_arbiter_beat_counter.sv | 26 ++
 rtl/rr_burst_arbiter.sv | 97 +++++++++
 tb/tb_rr_burst_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and the round-robin search helper for rr_burst_arbiter.
// The helper searches a fixed-width vector so it works for any N_REQ up to RR_MAX_REQ.
package rr_arb_pkg;

   typedef enum logic {
      RR_IDLE  = 1'b0,
      RR_BURST = 1'b1
   } rr_arb_state_e;

   localparam int unsigned RR_MAX_REQ   = 32;
   localparam int unsigned RR_MAX_IDX_W = 5;

   // First set index at or after ptr, wrapping at n; returns ptr when nothing is set.
   function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                           input int unsigned             ptr,
                                           input int unsigned             n);
      int unsigned sel;
      int unsigned idx;
      logic        found;
      sel   = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
         idx = (ptr + i) % n;
         if (!found && (i < n) && valid[idx[RR_MAX_IDX_W-1:0]]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Requester-side and downstream-side signals of rr_burst_arbiter.
// slave is the arbiter's view, master is the view of the surrounding logic.
interface rr_burst_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*LEN_W-1:0]  req_len;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    out_valid;
   logic [DATA_W-1:0]       out_data;
   logic [ID_W-1:0]         out_id;
   logic                    out_last;
   logic                    out_ready;
   logic                    busy;

   modport slave (
      input  req_valid, req_len, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, out_last, busy
   );

   modport master (
      output req_valid, req_len, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, out_last, busy
   );
endinterface

// File: rtl/rr_burst_arbiter_beat_counter.sv
// Beat counter for the granted burst; clr wins over inc, last flags count == len.
module arb_beat_counter #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [LEN_W-1:0] len,
   output logic [LEN_W-1:0] count,
   output logic             last
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + LEN_W'(1);
      end
   end

   assign last = (count == len);

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one requester owns the downstream port for len+1 beats.
// Define RR_ARB_BACK_TO_BACK_EN to re-arbitrate on the last beat with no IDLE bubble.
module rr_burst_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   rr_burst_arbiter_if.slave  bus
);

   localparam int ID_W = $clog2(N_REQ);

   rr_arb_state_e    state;
   logic [ID_W-1:0]  gnt_id;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  pick_id;
   logic [ID_W-1:0]  pick_next;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] beat;
   logic             any_req;
   logic             accept;
   logic             last;
   logic             clr;
   logic             inc;
   logic             grant_now;
   int unsigned      pick_full;

   always_comb begin
      any_req   = |bus.req_valid;
      pick_full = rr_pick(RR_MAX_REQ'(bus.req_valid), 32'(rr_ptr), N_REQ);
      pick_id   = pick_full[ID_W-1:0];
      pick_next = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);
   end

   always_comb begin
      accept = (state == RR_BURST) && bus.req_valid[gnt_id] && bus.out_ready;
`ifdef RR_ARB_BACK_TO_BACK_EN
      // The closing beat doubles as an arbitration slot; rr_ptr already excludes the holder.
      grant_now = any_req && ((state == RR_IDLE) || (accept && last));
`else
      grant_now = any_req && (state == RR_IDLE);
`endif
      clr = (state == RR_IDLE) || (accept && last);
      inc = accept && !last;
   end

   arb_beat_counter #(
      .LEN_W (LEN_W)
   ) u_beat (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (inc),
      .len   (len_q),
      .count (beat),
      .last  (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RR_IDLE;
         gnt_id <= '0;
         rr_ptr <= '0;
         len_q  <= '0;
      end else if (grant_now) begin
         state  <= RR_BURST;
         gnt_id <= pick_id;
         len_q  <= bus.req_len[pick_id*LEN_W +: LEN_W];
         rr_ptr <= pick_next;
      end else if (accept && last) begin
         state  <= RR_IDLE;
      end
   end

   // Outputs decode straight from state so reset clears them without a clock edge.
   always_comb begin
      bus.req_ready = '0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_id    = '0;
      bus.out_last  = 1'b0;
      bus.busy      = 1'b0;
      if (state == RR_BURST) begin
         bus.req_ready[gnt_id] = bus.out_ready;
         bus.out_valid         = bus.req_valid[gnt_id];
         bus.out_data          = bus.req_data[gnt_id*DATA_W +: DATA_W];
         bus.out_id            = gnt_id;
         bus.out_last          = last;
         bus.busy              = 1'b1;
      end
   end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed scenarios plus randomized traffic against a burst-level model.
module tb_rr_burst_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rr_burst_arbiter_if #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW)) bus ();

   rr_burst_arbiter #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc;

   // Burst-level reference: who owns the port, how many beats remain, next search start.
   bit m_busy;
   int m_gnt;
   int m_ptr;
   int m_left;

   int acc_id[$];
   bit acc_last[$];
   int acc_cyc[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_grant(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(m_ptr + k) % N]) begin
            m_gnt  = (m_ptr + k) % N;
            m_left = int'(bus.req_len[m_gnt*LW +: LW]) + 1;
            m_ptr  = (m_gnt + 1) % N;
            m_busy = 1'b1;
            break;
         end
      end
   endfunction

   task automatic drive(input logic [N-1:0] v, input logic r);
      bus.req_valid = v;
      bus.out_ready = r;
      #1;
      if (bus.out_valid === 1'b1 && r) begin
         acc_id.push_back(int'(bus.out_id));
         acc_last.push_back(bus.out_last);
         acc_cyc.push_back(cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_busy = 1'b0; m_gnt = 0; m_ptr = 0; m_left = 0;
      acc_id.delete(); acc_last.delete(); acc_cyc.delete();
      cyc = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = '0; bus.req_len = '0; bus.req_data = '0; bus.out_ready = 1'b0;
      #1;
      tests_run += 4;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
      if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
      if (bus.req_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready: got %0h want 0", bus.req_ready); end
      if (bus.out_id !== '0) begin tests_failed++; $display("FAIL reset_out_id: got %0h want 0", bus.out_id); end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_single_burst();
      logic [DW-1:0] d0;
      logic          exp_busy5;
`ifdef RR_ARB_BACK_TO_BACK_EN
      exp_busy5 = 1'b1;
`else
      exp_busy5 = 1'b0;
`endif
      do_reset();
      d0 = $urandom;
      bus.req_len[0*LW +: LW] = 4'd3;
      bus.req_data[0*DW +: DW] = d0;
      for (int c = 0; c < 5; c++) begin
         drive(4'b0001, 1'b1);
         if (c == 1) begin
            tests_run++;
            if (bus.out_data !== d0) begin tests_failed++; $display("FAIL single_data: got %0h want %0h", bus.out_data, d0); end
         end
         tick();
      end
      drive(4'b0000, 1'b1);
      tests_run += 3;
      if (bus.busy !== exp_busy5) begin tests_failed++; $display("FAIL single_busy_after: got %0b want %0b", bus.busy, exp_busy5); end
      if (acc_id.size() != 4) begin tests_failed++; $display("FAIL single_beats: got %0d want 4", acc_id.size()); end
      if (acc_cyc.size() == 0 || acc_cyc[0] != 1) begin tests_failed++; $display("FAIL single_first_beat_cycle: got %0d want 1", acc_cyc.size() ? acc_cyc[0] : -1); end
      for (int i = 0; i < acc_id.size() && i < 4; i++) begin
         tests_run += 2;
         if (acc_id[i] != 0) begin tests_failed++; $display("FAIL single_id beat %0d: got %0d want 0", i, acc_id[i]); end
         if (acc_last[i] != (i == 3)) begin tests_failed++; $display("FAIL single_last beat %0d: got %0b want %0b", i, acc_last[i], i == 3); end
      end
   endtask

   task automatic test_fairness();
      int gap;
`ifdef RR_ARB_BACK_TO_BACK_EN
      gap = 1;
`else
      gap = 2;
`endif
      do_reset();
      bus.req_len = '0;
      for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = 32'hA000_0000 + i;
      for (int c = 0; c < 13; c++) begin
         drive(4'b1111, 1'b1);
         tick();
      end
      tests_run++;
      if (acc_id.size() < 6) begin tests_failed++; $display("FAIL fair_count: got %0d want >=6", acc_id.size()); end
      for (int i = 0; i < 6 && i < acc_id.size(); i++) begin
         tests_run++;
         if (acc_id[i] != i % N) begin tests_failed++; $display("FAIL fair_order grant %0d: got %0d want %0d", i, acc_id[i], i % N); end
         if (i > 0) begin
            tests_run++;
            if (acc_cyc[i] - acc_cyc[i-1] != gap) begin tests_failed++; $display("FAIL fair_spacing grant %0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], gap); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] pat;
      pat = 5'b10101;
      do_reset();
      bus.req_len[2*LW +: LW] = 4'd2;
      drive(4'b0100, 1'b1);
      tick();
      for (int c = 0; c < 5; c++) begin
         drive(4'b0100, pat[c]);
         tests_run++;
         if (bus.req_ready !== (N'(pat[c]) << 2)) begin tests_failed++; $display("FAIL bp_req_ready cyc %0d: got %0h want %0h", c, bus.req_ready, N'(pat[c]) << 2); end
         tick();
      end
      tests_run++;
      if (acc_id.size() != 3) begin tests_failed++; $display("FAIL bp_beats: got %0d want 3", acc_id.size()); end
      for (int i = 0; i < acc_id.size() && i < 3; i++) begin
         tests_run += 2;
         if (acc_id[i] != 2) begin tests_failed++; $display("FAIL bp_id beat %0d: got %0d want 2", i, acc_id[i]); end
         if (acc_last[i] != (i == 2)) begin tests_failed++; $display("FAIL bp_last beat %0d: got %0b want %0b", i, acc_last[i], i == 2); end
      end
   endtask

   task automatic test_valid_gap();
      logic [N-1:0] v;
      do_reset();
      bus.req_len[1*LW +: LW] = 4'd3;
      bus.req_len[3*LW +: LW] = 4'd1;
      drive(4'b1010, 1'b1);
      tick();
      bus.req_len[1*LW +: LW] = 4'd15;
      for (int c = 1; c < 8; c++) begin
         v = (c >= 3 && c <= 5) ? 4'b1000 : 4'b1010;
         drive(v, 1'b1);
         tests_run += 2;
         if (bus.out_id !== IW'(1)) begin tests_failed++; $display("FAIL gap_out_id cyc %0d: got %0d want 1", c, bus.out_id); end
         if (bus.out_valid !== v[1]) begin tests_failed++; $display("FAIL gap_out_valid cyc %0d: got %0b want %0b", c, bus.out_valid, v[1]); end
         tick();
      end
      tests_run++;
      if (acc_id.size() != 4) begin tests_failed++; $display("FAIL gap_beats: got %0d want 4", acc_id.size()); end
      for (int i = 0; i < acc_id.size() && i < 4; i++) begin
         tests_run++;
         if (acc_last[i] != (i == 3)) begin tests_failed++; $display("FAIL gap_last beat %0d: got %0b want %0b", i, acc_last[i], i == 3); end
      end
   endtask

   task automatic test_wrap_priority();
      logic [N-1:0] pend;
      int           n0;
      int           want[3];
      want = '{2, 3, 1};
      do_reset();
      bus.req_len = '0;
      drive(4'b0100, 1'b1);
      tick();
      pend = 4'b1110;
      for (int c = 0; c < 10; c++) begin
         n0 = acc_id.size();
         drive(pend, 1'b1);
         if (acc_id.size() > n0 && acc_last[n0]) pend[acc_id[n0]] = 1'b0;
         tick();
      end
      tests_run++;
      if (acc_id.size() < 3) begin tests_failed++; $display("FAIL wrap_count: got %0d want >=3", acc_id.size()); end
      for (int i = 0; i < 3 && i < acc_id.size(); i++) begin
         tests_run++;
         if (acc_id[i] != want[i]) begin tests_failed++; $display("FAIL wrap_order grant %0d: got %0d want %0d", i, acc_id[i], want[i]); end
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      bus.req_len[0*LW +: LW] = 4'd5;
      for (int c = 0; c < 3; c++) begin
         drive(4'b0001, 1'b1);
         tick();
      end
      drive(4'b0001, 1'b1);
      tests_run++;
      if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre_valid: got %0b want 1", bus.out_valid); end
      #1;
      rst = 1'b1;
      #1;
      tests_run += 5;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %0b want 0", bus.busy); end
      if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_out_valid: got %0b want 0", bus.out_valid); end
      if (bus.req_ready !== '0) begin tests_failed++; $display("FAIL rstmid_req_ready: got %0h want 0", bus.req_ready); end
      if (bus.out_data !== '0) begin tests_failed++; $display("FAIL rstmid_out_data: got %0h want 0", bus.out_data); end
      if (bus.out_last !== 1'b0) begin tests_failed++; $display("FAIL rstmid_out_last: got %0b want 0", bus.out_last); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      acc_id.delete(); acc_last.delete(); acc_cyc.delete();
      bus.req_len = '0;
      drive(4'b0101, 1'b1);
      tick();
      drive(4'b0101, 1'b1);
      tests_run += 2;
      if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_regrant_valid: got %0b want 1", bus.out_valid); end
      if (bus.out_id !== IW'(0)) begin tests_failed++; $display("FAIL rstmid_regrant_id: got %0d want 0", bus.out_id); end
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0]  v;
      logic          r;
      logic          exp_valid, exp_last;
      logic [IW-1:0] exp_id;
      logic [DW-1:0] exp_data;
      logic [N-1:0]  exp_rdy;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         v = N'($urandom_range(0, 15));
         if (m_busy && $urandom_range(0, 3) != 0) v[m_gnt] = 1'b1;
         r = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            bus.req_len[i*LW +: LW]  = LW'($urandom_range(0, 7));
            bus.req_data[i*DW +: DW] = $urandom;
         end
         drive(v, r);
         exp_valid = m_busy ? v[m_gnt] : 1'b0;
         exp_id    = m_busy ? IW'(m_gnt) : '0;
         exp_last  = m_busy && (m_left == 1);
         exp_data  = m_busy ? bus.req_data[m_gnt*DW +: DW] : '0;
         exp_rdy   = m_busy ? (N'(r) << m_gnt) : '0;
         tests_run += 6;
         if (bus.busy !== m_busy) begin tests_failed++; $display("FAIL rand_busy cyc %0d: got %0b want %0b", c, bus.busy, m_busy); end
         if (bus.out_valid !== exp_valid) begin tests_failed++; $display("FAIL rand_out_valid cyc %0d: got %0b want %0b", c, bus.out_valid, exp_valid); end
         if (bus.out_id !== exp_id) begin tests_failed++; $display("FAIL rand_out_id cyc %0d: got %0d want %0d", c, bus.out_id, exp_id); end
         if (bus.out_last !== exp_last) begin tests_failed++; $display("FAIL rand_out_last cyc %0d: got %0b want %0b", c, bus.out_last, exp_last); end
         if (bus.out_data !== exp_data) begin tests_failed++; $display("FAIL rand_out_data cyc %0d: got %0h want %0h", c, bus.out_data, exp_data); end
         if (bus.req_ready !== exp_rdy) begin tests_failed++; $display("FAIL rand_req_ready cyc %0d: got %0h want %0h", c, bus.req_ready, exp_rdy); end
         @(posedge clk);
         if (!m_busy) begin
            if (v != '0) model_grant(v);
         end else if (v[m_gnt] && r) begin
            if (m_left == 1) begin
               m_busy = 1'b0;
`ifdef RR_ARB_BACK_TO_BACK_EN
               if (v != '0) model_grant(v);
`endif
            end else begin
               m_left--;
            end
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_fairness();
      test_backpressure();
      test_valid_gap();
      test_wrap_priority();
      test_reset_mid_burst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
